programmable_clock_divider: RTL and testbench

PROGRAMMABLE_CLOCK_DIVIDER -- requirements
Module: programmable_clock_divider

---
 rtl/programmable_clock_divider.sv | 64 ++++++
 tb/tb_programmable_clock_divider.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/programmable_clock_divider.sv
// Multi-channel programmable clock divider: each channel produces a 50%-duty
// divided clock of period 2*half plus a one-cycle tick on every rising edge.
module programmable_clock_divider #(
  parameter int unsigned COUNT_WIDTH  = 21,
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned DEFAULT_HALF = 50000
) (
  input  logic                          clock50,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_CH-1:0]             load_mask,
  input  logic [NUM_CH*COUNT_WIDTH-1:0] half_period_in,
  output logic [NUM_CH-1:0]             clock_out,
  output logic [NUM_CH-1:0]             tick
);

  localparam int unsigned CW = COUNT_WIDTH;
  localparam logic [CW-1:0] HALF_RST = CW'(DEFAULT_HALF);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CW-1:0] half_q;
    logic [CW-1:0] cnt_q;
    logic          clk_q;
    logic          tick_q;
    logic          stopped_c;
    logic          at_term_c;

    // '>=' keeps the counter bounded even if it somehow sits above half-1
    assign stopped_c = (half_q == '0);
    assign at_term_c = !stopped_c && (cnt_q >= half_q - CW'(1));

    // Priority: reset, then load (phase-align), then freeze, then count
    always_ff @(posedge clock50) begin
      if (reset) begin
        half_q <= HALF_RST;
        cnt_q  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (load_mask[c]) begin
        half_q <= half_period_in[c*CW +: CW];
        cnt_q  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (!enable) begin
        tick_q <= 1'b0;
      end else if (stopped_c) begin
        cnt_q  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (at_term_c) begin
        cnt_q  <= '0;
        clk_q  <= ~clk_q;
        tick_q <= ~clk_q;
      end else begin
        cnt_q  <= cnt_q + CW'(1);
        tick_q <= 1'b0;
      end
    end

    assign clock_out[c] = clk_q;
    assign tick[c]      = tick_q;
  end

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Directed-vector bench for programmable_clock_divider (2 channels, short default half).
module tb_programmable_clock_divider;

  localparam int unsigned CW    = 21;
  localparam int unsigned NCH   = 2;
  localparam int unsigned DHALF = 10;

  logic                clock50;
  logic                reset;
  logic                enable;
  logic [NCH-1:0]      load_mask;
  logic [NCH*CW-1:0]   half_period_in;
  logic [NCH-1:0]      clock_out;
  logic [NCH-1:0]      tick;

  programmable_clock_divider #(
    .COUNT_WIDTH (CW),
    .NUM_CH      (NCH),
    .DEFAULT_HALF(DHALF)
  ) dut (
    .clock50       (clock50),
    .reset         (reset),
    .enable        (enable),
    .load_mask     (load_mask),
    .half_period_in(half_period_in),
    .clock_out     (clock_out),
    .tick          (tick)
  );

  initial clock50 = 1'b0;
  always #5 clock50 = ~clock50;

  typedef struct {
    logic          rst;
    logic          en;
    logic [1:0]    ld;
    logic [CW-1:0] h0;
    logic [CW-1:0] h1;
    logic [1:0]    clk;
    logic [1:0]    tk;
  } vec_t;

  vec_t vecs[$];
  int   applied;
  int   miscompares;

  task automatic add(input logic r, input logic e, input logic [1:0] l,
                     input int h0, input int h1,
                     input logic [1:0] c, input logic [1:0] t);
    vec_t v;
    v.rst = r; v.en = e; v.ld = l;
    v.h0 = CW'(h0); v.h1 = CW'(h1);
    v.clk = c; v.tk = t;
    vecs.push_back(v);
  endtask

  task automatic apply_and_check(input string name, input int idx,
                                 input logic r, input logic e, input logic [1:0] l,
                                 input logic [CW-1:0] h0, input logic [CW-1:0] h1,
                                 input logic [1:0] c, input logic [1:0] t);
    @(negedge clock50);
    reset          = r;
    enable         = e;
    load_mask      = l;
    half_period_in = {h1, h0};
    @(posedge clock50);
    #1;
    applied++;
    if (clock_out !== c || tick !== t) begin
      miscompares++;
      $display("FAIL %s[%0d]: clock_out got %b want %b, tick got %b want %b",
               name, idx, clock_out, c, tick, t);
    end
  endtask

  initial begin
    applied = 0;
    miscompares = 0;
    reset = 1'b1;
    enable = 1'b0;
    load_mask = '0;
    half_period_in = '0;

    // reset, then load ch0=3 ch1=1 while disabled
    add(1, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    add(0, 0, 2'b11, 3, 1, 2'b00, 2'b00);
    // ch0 period 6, ch1 period 2
    add(0, 1, 2'b00, 0, 0, 2'b10, 2'b10);
    add(0, 1, 2'b00, 0, 0, 2'b00, 2'b00);
    add(0, 1, 2'b00, 0, 0, 2'b11, 2'b11);
    add(0, 1, 2'b00, 0, 0, 2'b01, 2'b00);
    add(0, 1, 2'b00, 0, 0, 2'b11, 2'b10);
    add(0, 1, 2'b00, 0, 0, 2'b00, 2'b00);
    add(0, 1, 2'b00, 0, 0, 2'b10, 2'b10);
    add(0, 1, 2'b00, 0, 0, 2'b00, 2'b00);
    add(0, 1, 2'b00, 0, 0, 2'b11, 2'b11);
    // stop ch1 with half=0; ch0 phase undisturbed
    add(0, 1, 2'b10, 0, 0, 2'b01, 2'b00);
    add(0, 1, 2'b00, 0, 0, 2'b01, 2'b00);
    add(0, 1, 2'b00, 0, 0, 2'b00, 2'b00);
    add(0, 1, 2'b00, 0, 0, 2'b00, 2'b00);
    add(0, 1, 2'b00, 0, 0, 2'b00, 2'b00);
    add(0, 1, 2'b00, 0, 0, 2'b01, 2'b01);
    // ch0 half 4, freeze 7 cycles at cnt=2 of the high phase
    add(0, 1, 2'b01, 4, 0, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) add(0, 1, 2'b00, 0, 0, 2'b00, 2'b00);
    add(0, 1, 2'b00, 0, 0, 2'b01, 2'b01);
    add(0, 1, 2'b00, 0, 0, 2'b01, 2'b00);
    add(0, 1, 2'b00, 0, 0, 2'b01, 2'b00);
    for (int i = 0; i < 7; i++) add(0, 0, 2'b00, 0, 0, 2'b01, 2'b00);
    add(0, 1, 2'b00, 0, 0, 2'b01, 2'b00);
    add(0, 1, 2'b00, 0, 0, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) add(0, 1, 2'b00, 0, 0, 2'b00, 2'b00);
    add(0, 1, 2'b00, 0, 0, 2'b01, 2'b01);
    // load ch0=5 on its terminal-count cycle: load wins
    for (int i = 0; i < 3; i++) add(0, 1, 2'b00, 0, 0, 2'b01, 2'b00);
    add(0, 1, 2'b01, 5, 0, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) add(0, 1, 2'b00, 0, 0, 2'b00, 2'b00);
    add(0, 1, 2'b00, 0, 0, 2'b01, 2'b01);
    // both at half 3, reset mid-high overriding a simultaneous load
    add(0, 1, 2'b11, 3, 3, 2'b00, 2'b00);
    add(0, 1, 2'b00, 0, 0, 2'b00, 2'b00);
    add(0, 1, 2'b00, 0, 0, 2'b00, 2'b00);
    add(0, 1, 2'b00, 0, 0, 2'b11, 2'b11);
    add(0, 1, 2'b00, 0, 0, 2'b11, 2'b00);
    add(1, 1, 2'b11, 3, 3, 2'b00, 2'b00);
    for (int i = 0; i < 9; i++) add(0, 1, 2'b00, 0, 0, 2'b00, 2'b00);
    add(0, 1, 2'b00, 0, 0, 2'b11, 2'b11);

    foreach (vecs[i])
      apply_and_check("vec", i, vecs[i].rst, vecs[i].en, vecs[i].ld,
                      vecs[i].h0, vecs[i].h1, vecs[i].clk, vecs[i].tk);

    // Free run at default half: rise at m=0, 10 high / 10 low, tick every 20
    for (int m = 1; m <= 45; m++) begin
      logic       hi;
      logic [1:0] ec;
      logic [1:0] et;
      hi = ((m / int'(DHALF)) % 2) == 0;
      ec = {hi, hi};
      et = ((m % int'(2 * DHALF)) == 0) ? 2'b11 : 2'b00;
      apply_and_check("run", m, 1'b0, 1'b1, 2'b00, '0, '0, ec, et);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
